// File: rtl/audio_i2s_tx_if.sv
// audio_i2s_tx_if
//   Sample handshake between the mixer stage and the I2S transmitter.
//   sample_l / sample_r : 16-bit signed stereo pair
//   sample_valid        : pair present this cycle (driven by the mixer)
//   sample_ready        : transmitter FIFO can accept a pair
//   master modport = mixer side, slave modport = transmitter side.
interface audio_i2s_tx_if;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic        sample_ready;

  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx
//   Buffers 16-bit stereo pairs in a 2-entry FIFO and serialises them as a
//   64-bit-per-frame I2S stream. The bit clock is divided from clk.
//
//   Parameters
//     SCLK_HALF : clk cycles per SCLK half-period (>= 1)
//   Ports
//     clk         : system clock, rising edge
//     reset_n     : synchronous active-low reset
//     samples     : sample handshake (slave side of audio_i2s_tx_if)
//     i2s_sclk    : bit clock (registered)
//     i2s_lrck    : word select, 0 = left, 1 = right (registered)
//     i2s_data    : serial data, MSB first (registered)
//     frame_start : one-cycle pulse on each frame load
//     overflow    : one-cycle pulse after a pair offered while full (dropped)
//     underrun    : one-cycle pulse when a frame load finds the FIFO empty
//   Configuration
//     I2S_LEFT_JUSTIFIED_EN : when defined, left-justified framing (no
//                             one-bit delay after LRCK); otherwise standard I2S.
module audio_i2s_tx #(
  parameter int SCLK_HALF = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  audio_i2s_tx_if.slave   samples,
  output logic            i2s_sclk,
  output logic            i2s_lrck,
  output logic            i2s_data,
  output logic            frame_start,
  output logic            overflow,
  output logic            underrun
);

  localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);

  // Divider / framing state
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic             sclk_reg, sclk_next;
  logic [5:0]       bit_cnt_reg, bit_cnt_next;
  logic             lrck_reg, lrck_next;
  logic             data_reg, data_next;
  logic             frame_start_reg;
  logic             overflow_reg;
  logic             underrun_reg;
  logic [31:0]      frame_reg, frame_next;

  // FIFO state: entries hold {L, R}
  logic [31:0]      fifo_mem [2];
  logic             wr_ptr_reg, rd_ptr_reg;
  logic [1:0]       count_reg, count_next;

  logic             tick, fall, load, ready, push, pop;
  logic [5:0]       slot;
  logic             slot_bit;

  always_comb begin
    tick  = (div_cnt_reg == DIV_LAST);
    fall  = tick && sclk_reg;
    load  = fall && (bit_cnt_reg == 6'd63);
    // Readiness depends on the registered count only, so a pop in the
    // same cycle never makes room for a push while full.
    ready = (count_reg != 2'd2);
    push  = samples.sample_valid && ready;
    pop   = load && (count_reg != 2'd0);

    div_cnt_next = tick ? '0 : div_cnt_reg + 1'b1;
    sclk_next    = tick ? ~sclk_reg : sclk_reg;
    bit_cnt_next = fall ? bit_cnt_reg + 6'd1 : bit_cnt_reg;
    // Empty FIFO at load keeps the previous frame (repeat last frame).
    frame_next   = pop ? fifo_mem[rd_ptr_reg] : frame_reg;
    lrck_next    = fall ? bit_cnt_next[5] : lrck_reg;

    // slot = position within the 32-bit half-frame window where the word
    // sits; bits 0..15 of each half carry data MSB first, bit 4 set = idle.
`ifdef I2S_LEFT_JUSTIFIED_EN
    slot = bit_cnt_next;
`else
    slot = bit_cnt_next - 6'd1;
`endif
    slot_bit  = slot[5] ? frame_next[{1'b0, ~slot[3:0]}]
                        : frame_next[{1'b1, ~slot[3:0]}];
    data_next = fall ? (~slot[4] & slot_bit) : data_reg;

    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_reg     <= '0;
      sclk_reg        <= 1'b0;
      bit_cnt_reg     <= 6'd63;
      lrck_reg        <= 1'b0;
      data_reg        <= 1'b0;
      frame_start_reg <= 1'b0;
      overflow_reg    <= 1'b0;
      underrun_reg    <= 1'b0;
      frame_reg       <= '0;
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
      count_reg       <= 2'd0;
    end else begin
      div_cnt_reg     <= div_cnt_next;
      sclk_reg        <= sclk_next;
      bit_cnt_reg     <= bit_cnt_next;
      lrck_reg        <= lrck_next;
      data_reg        <= data_next;
      frame_start_reg <= load;
      overflow_reg    <= samples.sample_valid && !ready;
      underrun_reg    <= load && (count_reg == 2'd0);
      frame_reg       <= frame_next;
      count_reg       <= count_next;
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  // Storage needs no reset: the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      fifo_mem[wr_ptr_reg] <= {samples.sample_l, samples.sample_r};
    end
  end

  assign samples.sample_ready = ready;
  assign i2s_sclk             = sclk_reg;
  assign i2s_lrck             = lrck_reg;
  assign i2s_data             = data_reg;
  assign frame_start          = frame_start_reg;
  assign overflow             = overflow_reg;
  assign underrun             = underrun_reg;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx
//   Randomised and directed stimulus for audio_i2s_tx, checked every cycle
//   against a cycle-count based reference model of the serial stream.
module tb_audio_i2s_tx;
  localparam int SH = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  audio_i2s_tx_if sif ();
  logic sclk, lrck, data, fs, ovf, unf;

  audio_i2s_tx #(.SCLK_HALF(SH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .samples     (sif),
    .i2s_sclk    (sclk),
    .i2s_lrck    (lrck),
    .i2s_data    (data),
    .frame_start (fs),
    .overflow    (ovf),
    .underrun    (unf)
  );

  int total = 0;
  int bad = 0;

  // Reference model state
  int          k = 0;          // clk edges since reset released
  int          bc = 63;        // expected bit counter
  logic        fall_ev = 1'b0;
  logic        ld = 1'b0;
  logic [31:0] q[$];
  logic [31:0] cur = '0;
  logic        e_fs = 0, e_ovf = 0, e_unf = 0;
  int          prev_fs_k = 0;

  // Observed-stream capture and event counters
  logic [15:0] cap_l = '0, cap_r = '0, done_l = '0, done_r = '0;
  int          ovf_cnt = 0, unf_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  function automatic logic in_l(input int n);
`ifdef I2S_LEFT_JUSTIFIED_EN
    return (n >= 0 && n <= 15);
`else
    return (n >= 1 && n <= 16);
`endif
  endfunction

  function automatic logic in_r(input int n);
`ifdef I2S_LEFT_JUSTIFIED_EN
    return (n >= 32 && n <= 47);
`else
    return (n >= 33 && n <= 48);
`endif
  endfunction

  // Bit of the {L,R} frame on the wire for bit position n.
  function automatic logic exp_data(input int n, input logic [31:0] f);
`ifdef I2S_LEFT_JUSTIFIED_EN
    if (in_l(n)) return f[31 - n];
    if (in_r(n)) return f[47 - n];
`else
    if (in_l(n)) return f[32 - n];
    if (in_r(n)) return f[48 - n];
`endif
    return 1'b0;
  endfunction

  task automatic step(input logic v, input logic [15:0] l, input logic [15:0] r, input logic rn);
    logic rdy_pre;
    logic e_sclk, e_lrck, e_data;
    sif.sample_valid = v;
    sif.sample_l     = l;
    sif.sample_r     = r;
    reset_n          = rn;
    @(posedge clk);
    if (!rn) begin
      k = 0; q.delete(); cur = '0;
      e_fs = 0; e_ovf = 0; e_unf = 0; fall_ev = 0; ld = 0;
      prev_fs_k = 0; cap_l = '0; cap_r = '0;
    end else begin
      rdy_pre = (q.size() < 2);
      k++;
      fall_ev = ((k % (2 * SH)) == 0);
      ld      = fall_ev && ((((k / (2 * SH)) + 63) % 64) == 0);
      e_unf   = ld && (q.size() == 0);
      if (ld && q.size() > 0) cur = q.pop_front();
      e_ovf   = v && !rdy_pre;
      if (v && rdy_pre) q.push_back({l, r});
      e_fs    = ld;
      if (ld) begin
        done_l = cap_l; done_r = cap_r; cap_l = '0; cap_r = '0;
      end
    end
    bc     = ((k / (2 * SH)) + 63) % 64;
    e_sclk = ((k / SH) % 2) == 1;
    e_lrck = (k < 2 * SH) ? 1'b0 : (bc >= 32);
    e_data = exp_data(bc, cur);
    #1;
    check("sclk",  {31'd0, sclk},  {31'd0, e_sclk});
    check("lrck",  {31'd0, lrck},  {31'd0, e_lrck});
    check("data",  {31'd0, data},  {31'd0, e_data});
    check("fs",    {31'd0, fs},    {31'd0, e_fs});
    check("ovf",   {31'd0, ovf},   {31'd0, e_ovf});
    check("unf",   {31'd0, unf},   {31'd0, e_unf});
    check("ready", {31'd0, sif.sample_ready}, {31'd0, (q.size() < 2)});
    if (ovf) ovf_cnt++;
    if (unf) unf_cnt++;
    if (rn && fall_ev) begin
      if (in_l(bc)) cap_l = {cap_l[14:0], data};
      if (in_r(bc)) cap_r = {cap_r[14:0], data};
    end
    if (fs) begin
      if (prev_fs_k > 0) check("fs_period", k - prev_fs_k, 128 * SH);
      prev_fs_k = k;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b1);
  endtask

  // Run idle until the DUT pulses frame_start, bounded.
  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      step(1'b0, 16'h0, 16'h0, 1'b1);
      n++;
    end while (!fs && n < 600);
    if (!fs) check("fs_timeout", 0, 1);
  endtask

  initial begin
    int n;
    logic v;
    // Reset
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 16'h0, 1'b0);
    check("rst_ready", {31'd0, sif.sample_ready}, 1);

    // Single pair, observe serialised words
    step(1'b1, 16'h8001, 16'h7FFE, 1'b1);
    wait_fs();
    wait_fs();
    check("word_l", {16'd0, done_l}, 32'h8001);
    check("word_r", {16'd0, done_r}, 32'h7FFE);
    $display("txn single pair: L=%h R=%h", done_l, done_r);

    // Three back-to-back pushes: third is dropped
    wait_fs();
    ovf_cnt = 0;
    step(1'b1, 16'hA1A1, 16'hA2A2, 1'b1);
    step(1'b1, 16'hB1B1, 16'hB2B2, 1'b1);
    step(1'b1, 16'hC1C1, 16'hC2C2, 1'b1);
    idle(3);
    check("ovf_once", ovf_cnt, 1);
    wait_fs();
    wait_fs();
    check("frame_a", {done_l, done_r}, 32'hA1A1A2A2);
    wait_fs();
    check("frame_b", {done_l, done_r}, 32'hB1B1B2B2);
    $display("txn overflow burst: ovf=%0d last=%h", ovf_cnt, {done_l, done_r});

    // Starvation repeats last frame
    step(1'b1, 16'h1234, 16'h5678, 1'b1);
    wait_fs();
    unf_cnt = 0;
    wait_fs();
    wait_fs();
    check("repeat", {done_l, done_r}, 32'h12345678);
    check("unf_count", unf_cnt, 2);
    $display("txn underrun: unf=%0d frame=%h", unf_cnt, {done_l, done_r});

    // Mid-frame reset at bit 20
    n = 0;
    while (bc != 20 && n < 300) begin
      step(1'b0, 16'h0, 16'h0, 1'b1);
      n++;
    end
    check("reach_bit20", bc, 20);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    check("rst_outs", {26'd0, sclk, lrck, data, fs, ovf, unf}, 0);
    check("rst_rdy", {31'd0, sif.sample_ready}, 1);
    n = 0;
    do begin
      step(1'b0, 16'h0, 16'h0, 1'b1);
      n++;
    end while (!fs && n < 600);
    check("first_load", n, 2 * SH);
    $display("txn mid-frame reset: first load after %0d cycles", n);

    // Randomised traffic with occasional bursts
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 99) < 3) || ((i % 700) >= 690);
      step(v, 16'($urandom), 16'($urandom), 1'b1);
    end
    $display("txn random run: ovf=%0d unf=%0d", ovf_cnt, unf_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
